// File: rtl/stc_frame_timer.sv
// stc_frame_timer
//   Bit-timing and frame sequencer for the STC demodulator. A free-running bit
//   counter produces the bit strobe. Once the pilot correlator reports a pilot,
//   the FSM aligns to the first pilot bit, then walks the pilot and data fields
//   of each frame. Lock is dropped after MISS_LIMIT consecutive frames without a pilot.
//
//   Build option: define STC_FRAME_RESYNC_EN so that pilotFound seen in PILOT/DATA
//   re-aligns the bit phase and frame position while lock is held.
//
// Ports
//   clk           sample clock, posedge
//   nReset        asynchronous active-low reset
//   enable        synchronous run enable; low forces SEARCH and clears outputs
//   clocksPerBit  bit period minus one, in clk cycles
//   pilotOffset   bits from pilotFound to the first pilot bit
//   pilotFound    one-cycle pulse from the pilot correlator
//   bitEn         one-cycle bit strobe
//   pilotWindow   high while in the pilot field
//   dataWindow    high while in the data field
//   bitIndex      bit position within the current field
//   frameStart    one-cycle pulse with the first pilot bit strobe of a frame
//   locked        frame lock indication
module stc_frame_timer #(
  parameter int unsigned PILOT_BITS = 128,
  parameter int unsigned DATA_BITS  = 3200,
  parameter int unsigned MISS_LIMIT = 3
) (
  input  logic        clk,
  input  logic        nReset,
  input  logic        enable,
  input  logic [15:0] clocksPerBit,
  input  logic [11:0] pilotOffset,
  input  logic        pilotFound,
  output logic        bitEn,
  output logic        pilotWindow,
  output logic        dataWindow,
  output logic [11:0] bitIndex,
  output logic        frameStart,
  output logic        locked
);

  localparam int unsigned CPB_W  = 16;
  localparam int unsigned IDX_W  = 12;
  localparam int unsigned MISS_W = (MISS_LIMIT < 2) ? 1 : $clog2(MISS_LIMIT);

`ifdef STC_FRAME_RESYNC_EN
  localparam bit RESYNC_EN = 1'b1;
`else
  localparam bit RESYNC_EN = 1'b0;
`endif

  typedef enum logic [1:0] {SEARCH, ALIGN, PILOT, DATA} state_t;

  state_t             state, stateNext;
  logic [CPB_W-1:0]   bitCnt, bitCntNext;
  logic [CPB_W-1:0]   cpbLatch, cpbLatchNext;
  logic               cpbLoaded;
  logic [IDX_W-1:0]   alignCnt, alignCntNext;
  logic [MISS_W-1:0]  missCnt, missCntNext;
  logic               hitFlag, hitFlagNext;
  logic [IDX_W-1:0]   bitIndexNext;
  logic               lockedNext;
  logic               tick;

  logic [CPB_W-1:0]   cpbEff;
  logic               wrap;
  logic               acquire;

  // Until the first cycle after reset the period comes straight from the register field.
  assign cpbEff  = cpbLoaded ? cpbLatch : clocksPerBit;
  assign wrap    = (bitCnt == cpbEff);
  // A pilot restarts bit phase from SEARCH, and also from PILOT/DATA when resync is built in.
  assign acquire = pilotFound &&
                   ((state == SEARCH) || (RESYNC_EN && ((state == PILOT) || (state == DATA))));

  // State and output registers.
  always_ff @(posedge clk or negedge nReset) begin
    if (!nReset) begin
      state       <= SEARCH;
      bitCnt      <= '0;
      cpbLatch    <= '0;
      cpbLoaded   <= 1'b0;
      alignCnt    <= '0;
      missCnt     <= '0;
      hitFlag     <= 1'b0;
      bitEn       <= 1'b0;
      pilotWindow <= 1'b0;
      dataWindow  <= 1'b0;
      bitIndex    <= '0;
      frameStart  <= 1'b0;
      locked      <= 1'b0;
    end else begin
      state       <= stateNext;
      bitCnt      <= bitCntNext;
      cpbLatch    <= cpbLatchNext;
      cpbLoaded   <= 1'b1;
      alignCnt    <= alignCntNext;
      missCnt     <= missCntNext;
      hitFlag     <= hitFlagNext;
      bitEn       <= tick;
      pilotWindow <= (stateNext == PILOT);
      dataWindow  <= (stateNext == DATA);
      bitIndex    <= bitIndexNext;
      frameStart  <= tick && (stateNext == PILOT) && (bitIndexNext == '0);
      locked      <= lockedNext;
    end
  end

  // Next-state: bit counter, alignment, field walk and lock tracking.
  always_comb begin
    stateNext    = state;
    bitCntNext   = wrap ? '0 : bitCnt + CPB_W'(1);
    cpbLatchNext = wrap ? clocksPerBit : cpbEff;
    alignCntNext = alignCnt;
    missCntNext  = missCnt;
    hitFlagNext  = hitFlag;
    bitIndexNext = bitIndex;
    lockedNext   = locked;
    tick         = wrap;

    if (!enable) begin
      stateNext    = SEARCH;
      bitCntNext   = '0;
      cpbLatchNext = clocksPerBit;
      alignCntNext = '0;
      missCntNext  = '0;
      hitFlagNext  = 1'b0;
      bitIndexNext = '0;
      lockedNext   = 1'b0;
      tick         = 1'b0;
    end else if (acquire) begin
      // Bit phase restarts at the pilot; any frame in progress is abandoned.
      bitCntNext   = '0;
      cpbLatchNext = cpbEff;
      tick         = 1'b0;
      alignCntNext = pilotOffset;
      missCntNext  = '0;
      hitFlagNext  = 1'b0;
      bitIndexNext = '0;
      if (pilotOffset == '0) begin
        stateNext  = PILOT;
        lockedNext = 1'b1;
      end else begin
        stateNext  = ALIGN;
      end
    end else begin
      if (pilotFound && (state != SEARCH)) hitFlagNext = 1'b1;
      if (bitEn) begin
        case (state)
          ALIGN: begin
            alignCntNext = alignCnt - IDX_W'(1);
            if (alignCnt == IDX_W'(1)) begin
              stateNext    = PILOT;
              bitIndexNext = '0;
              lockedNext   = 1'b1;
            end
          end
          PILOT: begin
            if (bitIndex == IDX_W'(PILOT_BITS - 1)) begin
              stateNext    = DATA;
              bitIndexNext = '0;
            end else begin
              bitIndexNext = bitIndex + IDX_W'(1);
            end
          end
          DATA: begin
            if (bitIndex == IDX_W'(DATA_BITS - 1)) begin
              // Frame end: a pilot on this very cycle still counts for the ending frame.
              stateNext    = PILOT;
              bitIndexNext = '0;
              hitFlagNext  = 1'b0;
              if (hitFlag || pilotFound) begin
                missCntNext = '0;
              end else if (missCnt == MISS_W'(MISS_LIMIT - 1)) begin
                stateNext   = SEARCH;
                lockedNext  = 1'b0;
                missCntNext = '0;
              end else begin
                missCntNext = missCnt + MISS_W'(1);
              end
            end else begin
              bitIndexNext = bitIndex + IDX_W'(1);
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule
